// File: rtl/reg_file_sb.sv
// Eight-entry register file with write-back bypass and a per-register
// pending-write scoreboard that stalls decode on RAW hazards or counter saturation.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_write_en,
    input  logic [2:0]        wb_write_dest,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic [2:0]        rd_addr_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              src_a_used,
    input  logic              src_b_used,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [2:0]        issue_dest,
    input  logic              flush,
    output logic              stall,
    output logic [7:0]        busy_vec
);

    localparam int         NREG     = 8;
    localparam logic [1:0] PEND_SAT = 2'(MAX_PEND);

    logic [DATA_W-1:0] regs [NREG];
    logic [1:0]        cnt  [NREG];

    logic       wb_live;
    logic       hazard_a;
    logic       hazard_b;
    logic       dest_sat;
    logic       accept;
    logic [7:0] inc_vec;
    logic [7:0] dec_vec;

    function automatic logic [DATA_W-1:0] read_port(
        input logic [2:0]        addr,
        input logic [DATA_W-1:0] stored,
        input logic              wen,
        input logic [2:0]        wdest,
        input logic [DATA_W-1:0] wdata
    );
        if (addr == 3'd0)
            return '0;
        if (wen && (wdest == addr))
            return wdata;
        return stored;
    endfunction

    // A source with exactly one pending write that retires this cycle is
    // satisfied through the bypass, so it does not stall.
    function automatic logic src_hazard(
        input logic       used,
        input logic [2:0] addr,
        input logic [1:0] count,
        input logic       wb_hit
    );
        return used && (addr != 3'd0) && (count != 2'd0)
               && !((count == 2'd1) && wb_hit);
    endfunction

    function automatic logic [1:0] cnt_next(
        input logic [1:0] cur,
        input logic       inc,
        input logic       dec
    );
        case ({inc, dec})
            2'b10:   return cur + 2'd1;
            2'b01:   return cur - 2'd1;
            default: return cur;
        endcase
    endfunction

    assign wb_live   = wb_write_en && (wb_write_dest != 3'd0);
    assign rd_data_a = read_port(rd_addr_a, regs[rd_addr_a], wb_write_en, wb_write_dest, wb_write_data);
    assign rd_data_b = read_port(rd_addr_b, regs[rd_addr_b], wb_write_en, wb_write_dest, wb_write_data);

    always_comb begin
        hazard_a = src_hazard(src_a_used, rd_addr_a, cnt[rd_addr_a],
                              wb_write_en && (wb_write_dest == rd_addr_a));
        hazard_b = src_hazard(src_b_used, rd_addr_b, cnt[rd_addr_b],
                              wb_write_en && (wb_write_dest == rd_addr_b));
        dest_sat = issue_wr && (issue_dest != 3'd0) && (cnt[issue_dest] == PEND_SAT)
                   && !(wb_write_en && (wb_write_dest == issue_dest));
        stall    = issue_valid && (hazard_a || hazard_b || dest_sat);
        accept   = issue_valid && !stall && !flush;
    end

    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        busy_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_vec[i]  = accept && issue_wr && (issue_dest == 3'(i));
            dec_vec[i]  = wb_live && (wb_write_dest == 3'(i)) && (cnt[i] != 2'd0);
            busy_vec[i] = (cnt[i] != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            if (wb_live)
                regs[wb_write_dest] <= wb_write_data;
            cnt[0] <= '0;
            // Flush drops tracking only; the register write above still lands.
            for (int i = 1; i < NREG; i++) begin
                if (flush)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt_next(cnt[i], inc_vec[i], dec_vec[i]);
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: expectations queued as each step is driven,
// then popped and compared mid-cycle against the combinational outputs.
module tb_reg_file_sb;

    localparam int DATA_W = 16;
    localparam int SEL_A = 0, SEL_B = 1, SEL_STALL = 2, SEL_BUSY = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_write_en;
    logic [2:0]        wb_write_dest;
    logic [DATA_W-1:0] wb_write_data;
    logic [2:0]        rd_addr_a;
    logic [2:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              src_a_used;
    logic              src_b_used;
    logic              issue_valid;
    logic              issue_wr;
    logic [2:0]        issue_dest;
    logic              flush;
    logic              stall;
    logic [7:0]        busy_vec;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    reg_file_sb #(.DATA_W(DATA_W), .MAX_PEND(3)) dut (
        .clk(clk), .rst(rst),
        .wb_write_en(wb_write_en), .wb_write_dest(wb_write_dest), .wb_write_data(wb_write_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .src_a_used(src_a_used), .src_b_used(src_b_used),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dest(issue_dest),
        .flush(flush), .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_A:     return rd_data_a;
            SEL_B:     return rd_data_b;
            SEL_STALL: return {15'b0, stall};
            default:   return {8'b0, busy_vec};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [15:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [15:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_write_en   = 1'b0;
        wb_write_dest = 3'd0;
        wb_write_data = '0;
        rd_addr_a     = 3'd0;
        rd_addr_b     = 3'd0;
        src_a_used    = 1'b0;
        src_b_used    = 1'b0;
        issue_valid   = 1'b0;
        issue_wr      = 1'b0;
        issue_dest    = 3'd0;
        flush         = 1'b0;
    endtask

    task automatic wb(input logic [2:0] dest, input logic [15:0] data);
        wb_write_en   = 1'b1;
        wb_write_dest = dest;
        wb_write_data = data;
    endtask

    task automatic issue(input logic wr, input logic [2:0] dest);
        issue_valid = 1'b1;
        issue_wr    = wr;
        issue_dest  = dest;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Out of reset: issue reading R3 must not stall, reads are zero
        issue(1'b0, 3'd0); src_a_used = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd7;
        expect_val("rst_rd_a", SEL_A, 16'h0000);
        expect_val("rst_rd_b", SEL_B, 16'h0000);
        expect_val("rst_busy", SEL_BUSY, 16'h0000);
        expect_val("rst_stall", SEL_STALL, 16'h0000);
        check_all();

        cyc(); idle();
        wb(3'd3, 16'h1234); rd_addr_a = 3'd5; rd_addr_b = 3'd3;
        expect_val("wr3_other_port", SEL_A, 16'h0000);
        expect_val("wr3_bypass_b", SEL_B, 16'h1234);
        check_all();

        cyc(); idle();
        rd_addr_a = 3'd3;
        expect_val("r3_read", SEL_A, 16'h1234);
        expect_val("r3_busy", SEL_BUSY, 16'h0000);
        check_all();

        cyc(); idle();
        wb(3'd0, 16'hFFFF); rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        expect_val("r0_no_bypass_a", SEL_A, 16'h0000);
        expect_val("r0_no_bypass_b", SEL_B, 16'h0000);
        check_all();

        cyc(); idle();
        wb(3'd5, 16'hBEEF); rd_addr_a = 3'd3; rd_addr_b = 3'd5;
        expect_val("r5_bypass_b", SEL_B, 16'hBEEF);
        expect_val("r3_hold_a", SEL_A, 16'h1234);
        check_all();

        cyc(); idle();
        rd_addr_a = 3'd0; rd_addr_b = 3'd5;
        expect_val("r0_after_wr", SEL_A, 16'h0000);
        expect_val("r5_stored", SEL_B, 16'hBEEF);
        check_all();

        // RAW on R2
        cyc(); idle();
        issue(1'b1, 3'd2);
        expect_val("iss2_stall", SEL_STALL, 16'h0000);
        expect_val("iss2_busy_pre", SEL_BUSY, 16'h0000);
        check_all();

        cyc(); idle();
        src_a_used = 1'b1; rd_addr_a = 3'd2;
        expect_val("novalid_nostall", SEL_STALL, 16'h0000);
        expect_val("r2_busy", SEL_BUSY, 16'h0004);
        check_all();

        cyc(); idle();
        issue(1'b0, 3'd0); src_a_used = 1'b1; rd_addr_a = 3'd2;
        expect_val("raw_a_stall", SEL_STALL, 16'h0001);
        expect_val("raw_a_busy", SEL_BUSY, 16'h0004);
        check_all();

        cyc(); idle();
        issue(1'b0, 3'd0); src_a_used = 1'b1; rd_addr_a = 3'd2; wb(3'd2, 16'h2222);
        expect_val("raw_a_wb_release", SEL_STALL, 16'h0000);
        expect_val("raw_a_wb_bypass", SEL_A, 16'h2222);
        check_all();

        cyc(); idle();
        rd_addr_a = 3'd2;
        expect_val("r2_retired_busy", SEL_BUSY, 16'h0000);
        expect_val("r2_value", SEL_A, 16'h2222);
        check_all();

        // Saturate R4
        cyc(); idle(); issue(1'b1, 3'd4);
        expect_val("r4_iss1", SEL_STALL, 16'h0000);
        check_all();
        cyc(); idle(); issue(1'b1, 3'd4);
        expect_val("r4_iss2", SEL_STALL, 16'h0000);
        expect_val("r4_busy", SEL_BUSY, 16'h0010);
        check_all();
        cyc(); idle(); issue(1'b1, 3'd4);
        expect_val("r4_iss3", SEL_STALL, 16'h0000);
        check_all();
        cyc(); idle(); issue(1'b1, 3'd4);
        expect_val("r4_sat_stall", SEL_STALL, 16'h0001);
        check_all();
        cyc(); idle(); issue(1'b1, 3'd4); wb(3'd4, 16'h4444);
        expect_val("r4_sat_wb_release", SEL_STALL, 16'h0000);
        check_all();
        cyc(); idle(); issue(1'b1, 3'd4);
        expect_val("r4_still_sat", SEL_STALL, 16'h0001);
        check_all();

        // Count 3 with a retiring write is still a source hazard
        cyc(); idle();
        issue(1'b0, 3'd0); src_a_used = 1'b1; rd_addr_a = 3'd4; wb(3'd4, 16'h4445);
        expect_val("r4_cnt3_src_stall", SEL_STALL, 16'h0001);
        check_all();

        cyc(); idle(); issue(1'b1, 3'd1);
        expect_val("r1_iss", SEL_STALL, 16'h0000);
        check_all();
        cyc(); idle(); issue(1'b1, 3'd6);
        expect_val("r6_iss1", SEL_STALL, 16'h0000);
        check_all();
        cyc(); idle(); issue(1'b1, 3'd6);
        expect_val("r6_iss2", SEL_STALL, 16'h0000);
        check_all();

        cyc(); idle();
        issue(1'b0, 3'd0); src_b_used = 1'b1; rd_addr_b = 3'd6;
        expect_val("raw_b_stall", SEL_STALL, 16'h0001);
        expect_val("pre_flush_busy", SEL_BUSY, 16'h0052);
        check_all();

        // Flush with a concurrent issue and register write
        cyc(); idle();
        issue(1'b1, 3'd1); flush = 1'b1; wb(3'd1, 16'h1111);
        expect_val("flush_cycle_stall", SEL_STALL, 16'h0000);
        check_all();

        cyc(); idle();
        rd_addr_a = 3'd1;
        expect_val("post_flush_busy", SEL_BUSY, 16'h0000);
        expect_val("flush_wr_kept", SEL_A, 16'h1111);
        check_all();

        // Reset mid-operation
        cyc(); idle(); issue(1'b1, 3'd7);
        check_all();
        cyc(); idle(); issue(1'b1, 3'd7);
        check_all();
        cyc(); idle();
        expect_val("r7_busy", SEL_BUSY, 16'h0080);
        check_all();

        cyc(); idle();
        rst = 1'b1; wb(3'd7, 16'hAAAA); issue(1'b1, 3'd7);
        check_all();

        cyc(); idle();
        rst = 1'b0; rd_addr_a = 3'd7; rd_addr_b = 3'd3;
        expect_val("rst_r7_zero", SEL_A, 16'h0000);
        expect_val("rst_r3_zero", SEL_B, 16'h0000);
        expect_val("rst_mid_busy", SEL_BUSY, 16'h0000);
        check_all();

        cyc(); idle();
        wb(3'd7, 16'h7777);
        expect_val("post_rst_wb_busy", SEL_BUSY, 16'h0000);
        check_all();

        cyc(); idle();
        rd_addr_a = 3'd7;
        expect_val("no_underflow_busy", SEL_BUSY, 16'h0000);
        expect_val("r7_written", SEL_A, 16'h7777);
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter: DATA_W, 16, register and write-back data width.
REQ-002 Parameter: MAX_PEND, 3, maximum in-flight writes per register; per-register counter is 2 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 wb_write_en  input  1  write-back write enable from WB stage.
REQ-006 wb_write_dest  input  3  write-back destination register index.
REQ-007 wb_write_data  input  DATA_W  write-back data.
REQ-008 rd_addr_a  input  3  read port A register index.
REQ-009 rd_addr_b  input  3  read port B register index.
REQ-010 rd_data_a  output  DATA_W  read port A data, combinational.
REQ-011 rd_data_b  output  DATA_W  read port B data, combinational.
REQ-012 src_a_used  input  1  issuing instruction reads port A.
REQ-013 src_b_used  input  1  issuing instruction reads port B.
REQ-014 issue_valid  input  1  decode presents an instruction this cycle.
REQ-015 issue_wr  input  1  issuing instruction writes a register.
REQ-016 issue_dest  input  3  issuing instruction destination index.
REQ-017 flush  input  1  discard all pending-write tracking.
REQ-018 stall  output  1  decode must hold; issue not accepted.
REQ-019 busy_vec  output  8  bit i high when pending count of register i is nonzero.

Function
REQ-020 Storage: eight DATA_W registers R0..R7; R0 reads 0 always, writes to R0 ignored.
REQ-021 Write: when wb_write_en=1 and wb_write_dest!=0, Rdest <= wb_write_data at clock edge.
REQ-022 Bypass: read of index equal to wb_write_dest while wb_write_en=1 and index!=0 returns wb_write_data same cycle.
REQ-023 Scoreboard: 2-bit pending counter per register R1..R7; R0 counter constant 0.
REQ-024 Issue accepted when issue_valid=1 and stall=0 and flush=0.
REQ-025 Accepted issue with issue_wr=1 and issue_dest!=0: counter[issue_dest] +1.
REQ-026 WB write with wb_write_dest!=0 and counter nonzero: counter[wb_write_dest] -1; counter zero: stays 0 (no underflow).
REQ-027 Increment and decrement to same register same cycle: counter unchanged.
REQ-028 Source hazard A: src_a_used=1, rd_addr_a!=0, counter[rd_addr_a]!=0, excluding case counter==1 and WB writing rd_addr_a this cycle.
REQ-029 Source hazard B: identical rule on port B.
REQ-030 Dest saturation: issue_wr=1, issue_dest!=0, counter[issue_dest]==MAX_PEND and not decremented this cycle.
REQ-031 stall = issue_valid AND (hazard A OR hazard B OR dest saturation); combinational; stall=0 when issue_valid=0.
REQ-032 Flush: all counters <= 0 at edge; flush overrides same-cycle issue and WB decrement; register write still performed.
REQ-033 busy_vec reflects registered counters (pre-edge), bit 0 always 0.

Reset
REQ-034 rst=1 at edge: R1..R7 <= 0, all counters <= 0; overrides write, issue, flush.
REQ-035 After reset: busy_vec=0, stall=0, rd_data_a=rd_data_b=0 absent bypass.
REQ-036 Reset mid-operation discards all pending tracking; subsequent WB writes to previously pending registers leave counters at 0.

Verification
REQ-037 Reset, WB write R3=0x1234, next cycle read A=3 -> rd_data_a=0x1234, busy_vec=0.
REQ-038 WB write R0=0xFFFF, read A=0 -> rd_data_a=0x0000; same-cycle WB write R5=0xBEEF with read B=5 -> rd_data_b=0xBEEF.
REQ-039 Issue dest=2, next cycle issue src_a=2 -> stall=1, busy_vec=0x04; WB write R2 that cycle -> stall=0, issue accepted.
REQ-040 Three issues to dest=4 (counter 3), fourth issue dest=4 -> stall=1; with same-cycle WB write R4 -> stall=0, counter stays 3.
REQ-041 Counters R1=1, R6=2, assert flush with issue dest=1 -> next cycle busy_vec=0, issue dropped.
REQ-042 Counter R7=2, assert rst with WB write R7=0xAAAA -> next cycle R7 reads 0, busy_vec=0.
